// File: rtl/me_frame_server.sv
// Motion-estimator host port: loads the R/S blocks, starts one job, serves reads, returns one result.
// Latency: zero-cycle reads; start pulses the cycle after the last byte; result appears the cycle after completed rises.
// Backpressure: load_ready is high only while loading; the result is held until res_ready. Define ME_TIMEOUT_EN to enable the watchdog.
module me_frame_server #(
  parameter int R_SIZE         = 256,
  parameter int S_SIZE         = 961,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       start,
  input  logic [7:0] AddressR,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] R,
  output logic [7:0] S1,
  output logic [7:0] S2,
  input  logic       completed,
  input  logic [7:0] BestDist,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_dist,
  output logic [3:0] res_mx,
  output logic [3:0] res_my,
  output logic       res_timeout,
  output logic       busy
);

  localparam int RW = $clog2(R_SIZE);
  localparam int SW = $clog2(S_SIZE);

  localparam logic [2:0] ST_LOAD_R = 3'd0;
  localparam logic [2:0] ST_LOAD_S = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  localparam logic [9:0] LAST_R = 10'(R_SIZE - 1);
  localparam logic [9:0] LAST_S = 10'(S_SIZE - 1);

  logic [2:0] state;
  logic [9:0] cnt;
  logic       completed_q;
  logic       load_fire;
  logic       capture;

  logic [7:0] mem_r [R_SIZE];
  logic [7:0] mem_s [S_SIZE];

  assign load_ready = (state == ST_LOAD_R) || (state == ST_LOAD_S);
  assign start      = (state == ST_START);
  assign busy       = !((state == ST_LOAD_R) && (cnt == 10'd0));
  assign load_fire  = load_valid && load_ready;
  // Only a fresh rising edge ends a job, so a level left over from the last job is ignored.
  assign capture    = (state == ST_RUN) && completed && !completed_q;

  // Zero-latency reads; anything beyond the block returns zero.
  assign R  = (int'(AddressR)  < R_SIZE) ? mem_r[AddressR[RW-1:0]]  : 8'h00;
  assign S1 = (int'(AddressS1) < S_SIZE) ? mem_s[AddressS1[SW-1:0]] : 8'h00;
  assign S2 = (int'(AddressS2) < S_SIZE) ? mem_s[AddressS2[SW-1:0]] : 8'h00;

  // Memory fill from the byte stream; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && load_fire) begin
      if (state == ST_LOAD_R) mem_r[cnt[RW-1:0]] <= load_data;
      else                    mem_s[cnt[SW-1:0]] <= load_data;
    end
  end

`ifdef ME_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] wd;
`else
  assign res_timeout = 1'b0;
`endif

  // Job sequencing: load R, load S, start, wait for the estimator, hand off the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD_R;
      cnt         <= 10'd0;
      completed_q <= 1'b0;
      res_valid   <= 1'b0;
      res_dist    <= 8'h00;
      res_mx      <= 4'h0;
      res_my      <= 4'h0;
`ifdef ME_TIMEOUT_EN
      wd          <= 13'd0;
      res_timeout <= 1'b0;
`endif
    end else begin
      completed_q <= completed;
      case (state)
        ST_LOAD_R: begin
          if (load_fire) begin
            if (cnt == LAST_R) begin
              state <= ST_LOAD_S;
              cnt   <= 10'd0;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        ST_LOAD_S: begin
          if (load_fire) begin
            if (cnt == LAST_S) begin
              state <= ST_START;
              cnt   <= 10'd0;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        ST_START: begin
          state <= ST_RUN;
`ifdef ME_TIMEOUT_EN
          wd    <= 13'd0;
`endif
        end
        ST_RUN: begin
          if (capture) begin
            res_dist  <= BestDist;
            res_mx    <= motionX;
            res_my    <= motionY;
            res_valid <= 1'b1;
            state     <= ST_RESULT;
`ifdef ME_TIMEOUT_EN
            res_timeout <= 1'b0;
          end else if (wd == WD_LAST) begin
            res_dist    <= 8'hFF;
            res_mx      <= 4'h0;
            res_my      <= 4'h0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= ST_RESULT;
          end else begin
            wd <= wd + 13'd1;
`endif
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_LOAD_R;
            cnt       <= 10'd0;
          end
        end
        default: state <= ST_LOAD_R;
      endcase
    end
  end

endmodule

// File: tb/tb_me_frame_server.sv
// Bench for me_frame_server: directed jobs, expected results queued and checked by a monitor.
// Runs the default build; with ME_TIMEOUT_EN defined the watchdog case expects an abort result.
module tb_me_frame_server;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       start;
  logic [7:0] AddressR;
  logic [9:0] AddressS1, AddressS2;
  logic [7:0] R, S1, S2;
  logic       completed;
  logic [7:0] BestDist;
  logic [3:0] motionX, motionY;
  logic       res_valid, res_ready;
  logic [7:0] res_dist;
  logic [3:0] res_mx, res_my;
  logic       res_timeout;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] x;
    logic [3:0] y;
    logic       t;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  me_frame_server #(.R_SIZE(256), .S_SIZE(961), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .AddressR(AddressR), .AddressS1(AddressS1),
    .AddressS2(AddressS2), .R(R), .S1(S1), .S2(S2), .completed(completed),
    .BestDist(BestDist), .motionX(motionX), .motionY(motionY), .res_valid(res_valid),
    .res_ready(res_ready), .res_dist(res_dist), .res_mx(res_mx), .res_my(res_my),
    .res_timeout(res_timeout), .busy(busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the head of the queue.
  always @(negedge clk) begin
    #1;
    if (!reset && res_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got dist=%0h mx=%0h my=%0h to=%0b, expected none",
                 res_dist, res_mx, res_my, res_timeout);
      end else begin
        if ({res_dist, res_mx, res_my, res_timeout} !== exp_q[0]) begin
          errors++;
          $display("FAIL result: got dist=%0h mx=%0h my=%0h to=%0b, expected dist=%0h mx=%0h my=%0h to=%0b",
                   res_dist, res_mx, res_my, res_timeout, exp_q[0].d, exp_q[0].x, exp_q[0].y, exp_q[0].t);
        end
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Streams n bytes (R[i]=i then S[i]=i[7:0]); with gap, load_valid toggles every cycle.
  task automatic load_bytes(input int n, input bit gap);
    int  idx = 0;
    int  cyc = 0;
    int  val;
    bit  ph  = 1'b0;
    while (idx < n && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      ph = ~ph;
      load_valid = gap ? ph : 1'b1;
      val = (idx < 256) ? idx : idx - 256;
      load_data = val[7:0];
      #1;
      if (load_valid && load_ready) idx++;
    end
    @(negedge clk);
    load_valid = 1'b0;
    if (idx < n) check("load_budget", idx, n);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full job load followed by the start-pulse and read-back checks.
  task automatic load_job(input bit gap);
    load_bytes(1217, gap);
    #1;
    check("load_ready_after_last", int'(load_ready), 0);
    check("start_pulse", int'(start), 1);
    check("busy_start", int'(busy), 1);
    @(negedge clk); #1;
    check("start_single", int'(start), 0);
    AddressR = 8'h10; AddressS1 = 10'd300; AddressS2 = 10'd960; #1;
    check("read_r10", int'(R), 8'h10);
    check("read_s300", int'(S1), 8'h2C);
    check("read_s960", int'(S2), 8'hC0);
    AddressR = 8'hFF; AddressS1 = 10'd961; AddressS2 = 10'd5; #1;
    check("read_rff", int'(R), 8'hFF);
    check("read_s_oob", int'(S1), 8'h00);
    check("read_s5", int'(S2), 8'h05);
  endtask

  // Waits for the queue to drain within a bound.
  task automatic wait_drain(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    AddressR = 8'h00; AddressS1 = 10'd0; AddressS2 = 10'd0;
    completed = 1'b0; BestDist = 8'h00; motionX = 4'h0; motionY = 4'h0; res_ready = 1'b0;
    wait_cycles(2);
    reset = 1'b0; #1;
    check("rst_load_ready", int'(load_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(start), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_dist", int'(res_dist), 0);
    check("rst_res_timeout", int'(res_timeout), 0);

    // Reset in the middle of the S load discards the partial job.
    load_bytes(356, 1'b0);
    #1;
    check("busy_mid_load", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    check("midrst_load_ready", int'(load_ready), 1);
    check("midrst_busy", int'(busy), 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (start) seen++;
    end
    check("midrst_no_start", seen, 0);

    // Job 1: full-rate load, result held under backpressure.
    load_job(1'b0);
    @(negedge clk);
    BestDist = 8'h25; motionX = 4'h3; motionY = 4'hC;
    exp_q.push_back('{d: 8'h25, x: 4'h3, y: 4'hC, t: 1'b0});
    completed = 1'b1;
    @(negedge clk); #1;
    check("res_valid_rise", int'(res_valid), 1);
    BestDist = 8'h99; motionX = 4'h7; motionY = 4'h7;
    repeat (5) begin
      @(negedge clk); #1;
      check("res_valid_held", int'(res_valid), 1);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; #1;
    check("job1_res_valid_clear", int'(res_valid), 0);
    check("job1_load_ready", int'(load_ready), 1);
    check("job1_busy", int'(busy), 0);
    check("job1_drained", exp_q.size(), 0);

    // Job 2: gapped load, stale completed level must not end the job.
    load_job(1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (res_valid) seen++;
    end
    check("stale_completed_ignored", seen, 0);
    @(negedge clk);
    completed = 1'b0;
    @(negedge clk);
    BestDist = 8'h07; motionX = 4'hA; motionY = 4'h1;
    exp_q.push_back('{d: 8'h07, x: 4'hA, y: 4'h1, t: 1'b0});
    completed = 1'b1;
    res_ready = 1'b1;
    @(negedge clk); #1;
    check("job2_res_valid", int'(res_valid), 1);
    @(negedge clk); #1;
    check("job2_res_valid_clear", int'(res_valid), 0);
    check("job2_load_ready", int'(load_ready), 1);
    res_ready = 1'b0;
    completed = 1'b0;

    // Job 3: estimator never completes.
    load_job(1'b0);
`ifdef ME_TIMEOUT_EN
    exp_q.push_back('{d: 8'hFF, x: 4'h0, y: 4'h0, t: 1'b1});
    res_ready = 1'b1;
    wait_drain("timeout_result", 40);
    res_ready = 1'b0;
`else
    seen = 0;
    repeat (10000) begin
      @(negedge clk); #1;
      if (res_valid) seen++;
    end
    check("no_watchdog_wait", seen, 0);
    check("still_running_busy", int'(busy), 1);
`endif

    wait_drain("final_drain", 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
